// File: rtl/matmul_sequencer_if.sv
// Memory port between the matrix-product sequencer and a word-addressed
// shared memory. The sequencer is the master and the memory is the slave.
// The slave grants a request in the same cycle it is presented. Read data
// returns exactly one cycle after a granted read.
interface matmul_sequencer_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_gnt;
  logic [WIDTH-1:0]  mem_rdata;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_gnt, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_gnt, mem_rdata
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Sequencer for C = A * B over a single shared memory port. A is MxN, B is
// NxN2 and C is MxN2. All three are stored row-major at consecutive word
// bases. Each product term costs one A read, one B read and one MAC cycle.
// Each C element costs one more cycle, for the write.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// RD_A  | read A[i][k]; the data lands during the first RD_B cycle
// RD_B  | read B[k][j]; a_reg captures A in the first RD_B cycle only
// MAC   | acc += a_reg * B word (B data on mem_rdata this cycle)
// WR    | write acc to C[i][j], then advance j/i or finish
// DONE  | one-cycle done pulse, then back to IDLE
module matmul_sequencer #(
  parameter int M      = 100,
  parameter int N      = 50,
  parameter int N2     = 2,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 16
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] cycle_count,
  matmul_sequencer_if.master mem
);

  localparam int A_BASE = 0;
  localparam int B_BASE = M * N;
  localparam int C_BASE = M * N + N * N2;
  localparam int IW = (M  > 1) ? $clog2(M)  : 1;
  localparam int JW = (N2 > 1) ? $clog2(N2) : 1;
  localparam int KW = (N  > 1) ? $clog2(N)  : 1;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR, DONE} state_t;

  state_t                   state;
  logic [IW-1:0]            i;
  logic [JW-1:0]            j;
  logic [KW-1:0]            k;
  logic signed [WIDTH-1:0]  acc;
  logic signed [WIDTH-1:0]  a_reg;
  logic signed [WIDTH-1:0]  acc_next;
  logic                     first_b;
  logic [ADDR_W-1:0]        addr_q;
  logic                     rd_q;
  logic                     wr_q;
  logic [WIDTH-1:0]         wdata_q;
  logic                     i_last;
  logic                     j_last;
  logic                     k_last;

  function automatic logic [ADDR_W-1:0] a_addr(input int row, input int col);
    return ADDR_W'(A_BASE + row * N + col);
  endfunction

  function automatic logic [ADDR_W-1:0] b_addr(input int row, input int col);
    return ADDR_W'(B_BASE + row * N2 + col);
  endfunction

  function automatic logic [ADDR_W-1:0] c_addr(input int row, input int col);
    return ADDR_W'(C_BASE + row * N2 + col);
  endfunction

  // Only the low WIDTH bits of the signed product are kept, so the
  // accumulator wraps instead of saturating.
  assign acc_next = acc + a_reg * $signed(mem.mem_rdata);
  assign i_last   = (i == IW'(M - 1));
  assign j_last   = (j == JW'(N2 - 1));
  assign k_last   = (k == KW'(N - 1));

  assign mem.mem_addr  = addr_q;
  assign mem.mem_rd    = rd_q;
  assign mem.mem_wr    = wr_q;
  assign mem.mem_wdata = wdata_q;

  // Sequencing FSM. Outputs are registered, so each branch loads the
  // outputs that belong to the state it is entering.
  always_ff @(posedge CLOCK_50) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      acc         <= '0;
      a_reg       <= '0;
      first_b     <= 1'b0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            i           <= '0;
            j           <= '0;
            k           <= '0;
            acc         <= '0;
            cycle_count <= '0;
            busy        <= 1'b1;
            rd_q        <= 1'b1;
            addr_q      <= a_addr(0, 0);
            state       <= RD_A;
          end
        end
        RD_A: begin
          cycle_count <= cycle_count + 32'd1;
          if (mem.mem_gnt) begin
            addr_q  <= b_addr(int'(k), int'(j));
            first_b <= 1'b1;
            state   <= RD_B;
          end
        end
        RD_B: begin
          cycle_count <= cycle_count + 32'd1;
          // A data is valid only in the cycle right after its granted read.
          if (first_b) begin
            a_reg   <= $signed(mem.mem_rdata);
            first_b <= 1'b0;
          end
          if (mem.mem_gnt) begin
            rd_q  <= 1'b0;
            state <= MAC;
          end
        end
        MAC: begin
          cycle_count <= cycle_count + 32'd1;
          acc         <= acc_next;
          if (k_last) begin
            wr_q    <= 1'b1;
            addr_q  <= c_addr(int'(i), int'(j));
            wdata_q <= acc_next;
            state   <= WR;
          end else begin
            k      <= k + KW'(1);
            rd_q   <= 1'b1;
            addr_q <= a_addr(int'(i), int'(k) + 1);
            state  <= RD_A;
          end
        end
        WR: begin
          cycle_count <= cycle_count + 32'd1;
          if (mem.mem_gnt) begin
            wr_q <= 1'b0;
            acc  <= '0;
            k    <= '0;
            if (j_last) begin
              j <= '0;
              i <= i + IW'(1);
            end else begin
              j <= j + JW'(1);
            end
            if (j_last && i_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rd_q   <= 1'b1;
              addr_q <= j_last ? a_addr(int'(i) + 1, 0) : a_addr(int'(i), 0);
              state  <= RD_A;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer. It drives a 2x2x2 instance and a 1x1x1
// instance, each behind a grant-controlled memory model. Expected C values
// come from the spec examples or from a plain triple-loop product.
module tb_matmul_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start1;
  logic        busy, done, busy1, done1;
  logic [31:0] cycle_count, cycle_count1;

  matmul_sequencer_if #(.WIDTH(32), .ADDR_W(16)) bus ();
  matmul_sequencer_if #(.WIDTH(32), .ADDR_W(16)) bus1 ();

  matmul_sequencer #(.M(2), .N(2), .N2(2), .WIDTH(32), .ADDR_W(16)) dut (
    .CLOCK_50(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .cycle_count(cycle_count), .mem(bus));

  matmul_sequencer #(.M(1), .N(1), .N2(1), .WIDTH(32), .ADDR_W(16)) dut1 (
    .CLOCK_50(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .cycle_count(cycle_count1), .mem(bus1));

  logic [31:0] mem  [16];
  logic [31:0] mem1 [4];
  logic [31:0] a_m [4];
  logic [31:0] b_m [4];
  logic [31:0] c_exp [4];

  int checks = 0, errors = 0;
  int cyc = 0, wr_cnt = 0, done_cnt = 0, stalls = 0, proto_err = 0;
  int last_wr_cyc = -1, done_cyc = -1;
  int gnt_mode = 0, rdb_left = 0, wr_left = 0;
  logic [31:0] a_reg_seen = '0;

  // Memory models. Read data is garbage except in the cycle after a granted read.
  always @(posedge clk) begin
    if (bus.mem_rd && bus.mem_gnt) bus.mem_rdata <= mem[bus.mem_addr[3:0]];
    else bus.mem_rdata <= $urandom;
    if (bus.mem_wr && bus.mem_gnt) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
  end

  always @(posedge clk) begin
    if (bus1.mem_rd && bus1.mem_gnt) bus1.mem_rdata <= mem1[bus1.mem_addr[1:0]];
    else bus1.mem_rdata <= $urandom;
    if (bus1.mem_wr && bus1.mem_gnt) mem1[bus1.mem_addr[1:0]] <= bus1.mem_wdata;
  end
  assign bus1.mem_gnt = 1'b1;

  // Grant generation and bus monitoring, evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (gnt_mode == 1) begin
      if (bus.mem_rd && bus.mem_addr >= 16'd4 && bus.mem_addr < 16'd8 && rdb_left > 0) begin
        bus.mem_gnt = 1'b0;
        rdb_left--;
        if (rdb_left == 0) a_reg_seen = dut.a_reg;
      end else if (bus.mem_wr && wr_left > 0) begin
        bus.mem_gnt = 1'b0;
        wr_left--;
      end else bus.mem_gnt = 1'b1;
    end else if (gnt_mode == 2) bus.mem_gnt = ($urandom_range(0, 2) != 0);
    else bus.mem_gnt = 1'b1;
    if ((bus.mem_rd || bus.mem_wr) && !bus.mem_gnt) stalls++;
    if (bus.mem_wr && bus.mem_gnt) begin wr_cnt++; last_wr_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (bus.mem_rd && bus.mem_wr) proto_err++;
    if (!busy && (bus.mem_rd || bus.mem_wr)) proto_err++;
    if ((bus.mem_rd || bus.mem_wr) && bus.mem_addr > 16'd11) proto_err++;
  end

  task automatic load_mats();
    for (int x = 0; x < 4; x++) begin
      mem[x] = a_m[x];
      mem[4 + x] = b_m[x];
      mem[8 + x] = 32'hDEAD_BEEF;
    end
  endtask

  task automatic ref_product();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        logic [31:0] s;
        s = '0;
        for (int t = 0; t < 2; t++) s = s + a_m[r*2+t] * b_m[t*2+c];
        c_exp[r*2+c] = s;
      end
  endtask

  task automatic do_run(input int budget, input bit poke, output bit ok);
    wr_cnt = 0; done_cnt = 0; stalls = 0; last_wr_cyc = -1; done_cyc = -1; ok = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; start = 1'b0; break; end
      start = poke && (n % 4 == 1);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    checks++; if ({bus.mem_rd, bus.mem_wr} !== 2'b00) begin errors++; $display("FAIL reset_rdwr got %b exp 00", {bus.mem_rd, bus.mem_wr}); end
    checks++; if (bus.mem_addr !== 16'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %0d exp 0", bus.mem_wdata); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycle_count got %0d exp 0", cycle_count); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    a_m = '{1, 2, 3, 4}; b_m = '{5, 6, 7, 8}; c_exp = '{19, 22, 43, 50};
    load_mats(); gnt_mode = 0;
    do_run(200, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got no done exp done"); end
    for (int r = 0; r < 4; r++) begin
      checks++; if (mem[8+r] !== c_exp[r]) begin errors++; $display("FAIL basic_C[%0d] got %0d exp %0d", r, $signed(mem[8+r]), $signed(c_exp[r])); end
    end
    checks++; if (cycle_count !== 32'd28) begin errors++; $display("FAIL basic_cycle_count got %0d exp 28", cycle_count); end
    checks++; if (done_cyc !== last_wr_cyc + 1) begin errors++; $display("FAIL basic_done_timing got %0d exp %0d", done_cyc, last_wr_cyc + 1); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d exp 1", done_cnt); end
    checks++; if (wr_cnt !== 4) begin errors++; $display("FAIL basic_writes got %0d exp 4", wr_cnt); end
  endtask

  task automatic test_signed();
    bit ok;
    a_m = '{-1, 2, 3, -4}; b_m = '{5, 6, 7, 8}; c_exp = '{9, 10, -13, -14};
    load_mats(); gnt_mode = 0;
    do_run(200, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL signed_timeout got no done exp done"); end
    for (int r = 0; r < 4; r++) begin
      checks++; if (mem[8+r] !== c_exp[r]) begin errors++; $display("FAIL signed_C[%0d] got %0d exp %0d", r, $signed(mem[8+r]), $signed(c_exp[r])); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    a_m = '{1, 2, 3, 4}; b_m = '{5, 6, 7, 8}; c_exp = '{19, 22, 43, 50};
    load_mats(); rdb_left = 3; wr_left = 2; gnt_mode = 1;
    do_run(200, 1'b0, ok);
    gnt_mode = 0;
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got no done exp done"); end
    for (int r = 0; r < 4; r++) begin
      checks++; if (mem[8+r] !== c_exp[r]) begin errors++; $display("FAIL stall_C[%0d] got %0d exp %0d", r, $signed(mem[8+r]), $signed(c_exp[r])); end
    end
    checks++; if (cycle_count !== 32'd33) begin errors++; $display("FAIL stall_cycle_count got %0d exp 33", cycle_count); end
    checks++; if (a_reg_seen !== a_m[0]) begin errors++; $display("FAIL stall_a_reg got %0d exp %0d", a_reg_seen, a_m[0]); end
  endtask

  task automatic test_wrap();
    bit ok;
    mem1[0] = 32'd65536; mem1[1] = 32'd65536; mem1[2] = 32'h1234_5678;
    ok = 1'b0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done1) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got no done exp done"); end
    checks++; if (mem1[2] !== 32'd0) begin errors++; $display("FAIL wrap_C got %0d exp 0", mem1[2]); end
    checks++; if (cycle_count1 !== 32'd4) begin errors++; $display("FAIL wrap_cycle_count got %0d exp 4", cycle_count1); end
  endtask

  task automatic test_start_busy();
    bit ok;
    a_m = '{2, 0, 1, 3}; b_m = '{4, 1, 5, 2}; ref_product();
    load_mats(); gnt_mode = 0;
    do_run(200, 1'b1, ok);
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busystart_done_pulses got %0d exp 1", done_cnt); end
    checks++; if (wr_cnt !== 4) begin errors++; $display("FAIL busystart_writes got %0d exp 4", wr_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busystart_idle got %0b exp 0", busy); end
    for (int r = 0; r < 4; r++) begin
      checks++; if (mem[8+r] !== c_exp[r]) begin errors++; $display("FAIL busystart_C[%0d] got %0d exp %0d", r, $signed(mem[8+r]), $signed(c_exp[r])); end
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 6; it++) begin
      for (int x = 0; x < 4; x++) begin
        a_m[x] = (it == 5) ? $urandom : $urandom_range(0, 200) - 100;
        b_m[x] = (it == 5) ? $urandom : $urandom_range(0, 200) - 100;
      end
      ref_product(); load_mats();
      gnt_mode = (it % 2 == 1) ? 2 : 0;
      do_run(600, 1'b0, ok);
      gnt_mode = 0;
      checks++; if (!ok) begin errors++; $display("FAIL random%0d_timeout got no done exp done", it); end
      for (int r = 0; r < 4; r++) begin
        checks++; if (mem[8+r] !== c_exp[r]) begin errors++; $display("FAIL random%0d_C[%0d] got %0d exp %0d", it, r, $signed(mem[8+r]), $signed(c_exp[r])); end
      end
      checks++; if (cycle_count !== 32'(28 + stalls)) begin errors++; $display("FAIL random%0d_cycle_count got %0d exp %0d", it, cycle_count, 28 + stalls); end
    end
  endtask

  task automatic test_abort();
    bit ok;
    int bc, w0;
    a_m = '{1, 2, 3, 4}; b_m = '{5, 6, 7, 8}; c_exp = '{19, 22, 43, 50};
    load_mats(); gnt_mode = 0; done_cnt = 0; bc = 0;
    @(negedge clk); start = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); start = 1'b0;
      if (busy) bc++;
      if (bc == 10) begin rst = 1'b0; break; end
    end
    @(negedge clk); rst = 1'b1;
    checks++; if (bc !== 10) begin errors++; $display("FAIL abort_reach got %0d exp 10", bc); end
    checks++; if ({busy, done, bus.mem_rd, bus.mem_wr} !== 4'b0000) begin errors++; $display("FAIL abort_ctrl got %b exp 0000", {busy, done, bus.mem_rd, bus.mem_wr}); end
    checks++; if ({bus.mem_addr, bus.mem_wdata, cycle_count} !== 80'd0) begin errors++; $display("FAIL abort_data got %0h exp 0", {bus.mem_addr, bus.mem_wdata, cycle_count}); end
    w0 = wr_cnt;
    repeat (20) @(negedge clk);
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL abort_writes got %0d exp %0d", wr_cnt, w0); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_done got %0d exp 0", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %0b exp 0", busy); end
    load_mats();
    do_run(200, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_rerun_timeout got no done exp done"); end
    for (int r = 0; r < 4; r++) begin
      checks++; if (mem[8+r] !== c_exp[r]) begin errors++; $display("FAIL abort_rerun_C[%0d] got %0d exp %0d", r, $signed(mem[8+r]), $signed(c_exp[r])); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; start1 = 1'b0; bus.mem_gnt = 1'b1;
    test_reset();
    test_basic();
    test_signed();
    test_stall();
    test_wrap();
    test_start_busy();
    test_random();
    test_abort();
    checks++; if (proto_err !== 0) begin errors++; $display("FAIL bus_protocol got %0d exp 0", proto_err); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter M, default 100: rows of matrix1.
REQ-002 SHALL have parameter N, default 50: columns of matrix1 / rows of matrix2.
REQ-003 SHALL have parameter N2, default 2: columns of matrix2.
REQ-004 SHALL have parameter WIDTH, default 32: data word width.
REQ-005 SHALL have parameter ADDR_W, default 16: word-address width.
REQ-006 SHALL have port CLOCK_50, input, 1: sole clock, all state on rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port start, input, 1: begin a matrix product when IDLE.
REQ-009 SHALL have port busy, output, 1: high in RD_A, RD_B, MAC and WR.
REQ-010 SHALL have port done, output, 1: one-cycle pulse at completion.
REQ-011 SHALL have port mem_addr, output, ADDR_W: word address of the current access.
REQ-012 SHALL have port mem_rd, output, 1: read request.
REQ-013 SHALL have port mem_wr, output, 1: write request.
REQ-014 SHALL have port mem_wdata, output, WIDTH: write data.
REQ-015 SHALL have port mem_gnt, input, 1: memory accepts the current request this cycle.
REQ-016 SHALL have port mem_rdata, input, WIDTH: read data, valid exactly one cycle after a granted read.
REQ-017 SHALL have port cycle_count, output, 32: busy cycles of the last or current run.

Function
REQ-018 SHALL use a word-addressed layout: A_BASE=0, B_BASE=M*N, C_BASE=M*N+N*N2, all row-major.
REQ-019 SHALL implement the states IDLE, RD_A, RD_B, MAC, WR and DONE.
REQ-020 SHALL, in IDLE on start=1, clear i, j, k, acc and cycle_count, then go to RD_A; start SHALL be ignored in every other state.
REQ-021 SHALL, in RD_A, assert mem_rd with mem_addr=A_BASE+i*N+k, and go to RD_B only when mem_gnt=1.
REQ-022 SHALL, in RD_B, assert mem_rd with mem_addr=B_BASE+k*N2+j, and go to MAC only when mem_gnt=1.
REQ-023 SHALL load a_reg from mem_rdata in the first RD_B cycle only, whether or not RD_B stalls.
REQ-024 SHALL, in MAC, set acc to acc+a_reg*mem_rdata as signed, truncated to WIDTH bits (wrap, no saturation), with no memory request.
REQ-025 SHALL, after MAC, go to WR if k==N-1; otherwise it SHALL increment k and go to RD_A.
REQ-026 SHALL, in WR, assert mem_wr with mem_addr=C_BASE+i*N2+j and mem_wdata=acc, and hold until mem_gnt=1.
REQ-027 SHALL, on a granted WR, clear acc and k, and advance j; when j wraps (j==N2-1) it SHALL set j=0 and increment i.
REQ-028 SHALL, on a granted WR with i==M-1 and j==N2-1, go to DONE; otherwise it SHALL go to RD_A.
REQ-029 SHALL, in DONE, pulse done for one cycle and return to IDLE; cycle_count SHALL hold until the next start.
REQ-030 SHALL never assert mem_rd and mem_wr together.
REQ-031 SHALL hold mem_rd=mem_wr=0 in IDLE, MAC and DONE, with mem_addr and mem_wdata don't-care when neither is asserted.
REQ-032 SHALL, on a stall (mem_gnt=0), hold the state, address, wdata, i, j, k and acc.
REQ-033 SHALL increment cycle_count on every busy cycle, including stall cycles, wrapping at 2^32.
REQ-034 SHALL have an unstalled latency of M*N2*(3N+1) busy cycles plus one DONE cycle.

Reset
REQ-035 SHALL, while rst=0 at a clock edge, enter IDLE and set busy=0, done=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, cycle_count=0, i=j=k=0, acc=0 and a_reg=0.
REQ-036 SHALL treat reset asserted mid-run as an abort: no further memory access, no done pulse.
REQ-037 SHALL require a new start after reset to begin a new run.

Verification
REQ-038 SHALL test M=N=N2=2, A=[1,2;3,4], B=[5,6;7,8], mem_gnt=1 -> C at addresses 8..11 = 19,22,43,50; done one cycle after the last write; cycle_count=28.
REQ-039 SHALL test signed operands, A=[-1,2;3,-4], B=[5,6;7,8] -> C=9,10,-13,-14.
REQ-040 SHALL test mem_gnt=0 for 3 cycles during one RD_B and 2 cycles during one WR -> C unchanged; cycle_count=33; a_reg equals the A word.
REQ-041 SHALL test wrap: WIDTH=32, M=N=N2=1, A=65536, B=65536 -> C=0; cycle_count=4.
REQ-042 SHALL test start pulsed while busy -> ignored; exactly one done pulse and M*N2 writes.
REQ-043 SHALL test rst=0 for one cycle in the 10th busy cycle -> IDLE next cycle, all outputs zero, no writes or done until a new start; a rerun then gives correct C.
